// File: rtl/page_table_walker_pkg.sv
// Shared types for the page table walker: FSM state and port encodings,
// default geometry, and the two-requester round-robin pick.
package page_table_walker_pkg;

    typedef enum logic [1:0] {
        PTW_IDLE = 2'd0,
        PTW_WALK = 2'd1,
        PTW_RESP = 2'd2
    } ptw_state_e;

    typedef enum logic {
        PTW_PORT_I = 1'b0,
        PTW_PORT_D = 1'b1
    } ptw_port_e;

    localparam int unsigned PTW_PAGE_WIDTH  = 20;
    localparam int unsigned PTW_WALK_DELAY  = 3;
    localparam int unsigned PTW_DELAY_WIDTH = 2;
    localparam int unsigned PTW_CNT_WIDTH   = 32;

    // Returns {grant_d, grant_i}; a sole requester always wins, a tie goes to prio.
    function automatic logic [1:0] ptw_rr_pick(input logic req_i, input logic req_d,
                                               input ptw_port_e prio);
        logic [1:0] pick;
        pick = 2'b00;
        if (req_i && req_d) begin
            if (prio == PTW_PORT_D) begin
                pick = 2'b10;
            end else begin
                pick = 2'b01;
            end
        end else begin
            pick = {req_d, req_i};
        end
        return pick;
    endfunction

endpackage

// File: rtl/page_table_walker_rr_arbiter.sv
// Round-robin arbiter between the ITLB and DTLB miss ports. Grants are
// combinational and one-hot; a grant is also the handshake.
module ptw_rr_arbiter
    import page_table_walker_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic req_i,
    input  logic req_d,
    output logic grant_i,
    output logic grant_d
);

    ptw_port_e  prio_r;
    logic [1:0] pick_s;

    // Grant selection, gated by enable
    always_comb begin
        pick_s = ptw_rr_pick(req_i, req_d, prio_r);
        if (enable) begin
            grant_i = pick_s[0];
            grant_d = pick_s[1];
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Priority moves to the port that was not just granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_r <= PTW_PORT_I;
        end else if (grant_d) begin
            prio_r <= PTW_PORT_I;
        end else if (grant_i) begin
            prio_r <= PTW_PORT_D;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/page_table_walker.sv
// Shared TLB refill responder: accepts one ITLB/DTLB miss at a time, waits
// WALK_DELAY cycles, then returns ppage = vpage + 1 (fault on vpage 0).
module page_table_walker
    import page_table_walker_pkg::*;
#(
    parameter int unsigned PAGE_WIDTH  = PTW_PAGE_WIDTH,
    parameter int unsigned WALK_DELAY  = PTW_WALK_DELAY,
    parameter int unsigned DELAY_WIDTH = PTW_DELAY_WIDTH,
    parameter int unsigned CNT_WIDTH   = PTW_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    input  logic [PAGE_WIDTH-1:0] i_req_vpage,
    output logic                  i_req_ready,
    input  logic                  d_req_valid,
    input  logic [PAGE_WIDTH-1:0] d_req_vpage,
    output logic                  d_req_ready,
    input  logic                  flush,
    output logic                  i_resp_valid,
    output logic                  d_resp_valid,
    output logic [PAGE_WIDTH-1:0] resp_vpage,
    output logic [PAGE_WIDTH-1:0] resp_ppage,
    output logic                  resp_fault,
    output logic [CNT_WIDTH-1:0]  walks_done,
    output logic [CNT_WIDTH-1:0]  faults_seen
);

    localparam logic [DELAY_WIDTH-1:0] DELAY_INIT = DELAY_WIDTH'(WALK_DELAY - 1);
    localparam logic [DELAY_WIDTH-1:0] DELAY_ZERO = {DELAY_WIDTH{1'b0}};
    localparam logic [PAGE_WIDTH-1:0]  PAGE_ZERO  = {PAGE_WIDTH{1'b0}};
    localparam logic [PAGE_WIDTH-1:0]  PAGE_ONE   = {{(PAGE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [PAGE_WIDTH-1:0] next_page(input logic [PAGE_WIDTH-1:0] vp);
        return vp + PAGE_ONE;
    endfunction

    ptw_state_e             state_r;
    ptw_state_e             state_nxt_s;
    ptw_port_e              port_r;
    logic [PAGE_WIDTH-1:0]  vpage_r;
    logic [DELAY_WIDTH-1:0] cnt_r;
    logic                   arb_enable_s;
    logic                   grant_i_s;
    logic                   grant_d_s;
    logic                   accept_s;
    logic                   own_valid_s;
    logic [PAGE_WIDTH-1:0]  own_vpage_s;
    logic                   walk_abort_s;
    logic                   enter_resp_s;
    logic                   i_resp_valid_r;
    logic                   d_resp_valid_r;
    logic [PAGE_WIDTH-1:0]  resp_vpage_r;
    logic [PAGE_WIDTH-1:0]  resp_ppage_r;
    logic                   resp_fault_r;
    logic [CNT_WIDTH-1:0]   walks_done_r;
    logic [CNT_WIDTH-1:0]   faults_seen_r;

    assign arb_enable_s = (state_r == PTW_IDLE) & ~flush;

    ptw_rr_arbiter u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (arb_enable_s),
        .req_i   (i_req_valid),
        .req_d   (d_req_valid),
        .grant_i (grant_i_s),
        .grant_d (grant_d_s)
    );

    assign accept_s    = grant_i_s | grant_d_s;
    assign i_req_ready = grant_i_s;
    assign d_req_ready = grant_d_s;

    // Live request of the port that owns the walk, watched for withdrawal
    always_comb begin
        if (port_r == PTW_PORT_D) begin
            own_valid_s = d_req_valid;
            own_vpage_s = d_req_vpage;
        end else begin
            own_valid_s = i_req_valid;
            own_vpage_s = i_req_vpage;
        end
    end

    assign walk_abort_s = flush | ~own_valid_s | (own_vpage_s != vpage_r);

    // Next-state logic; an abort wins over a finishing countdown
    always_comb begin
        state_nxt_s  = state_r;
        enter_resp_s = 1'b0;
        case (state_r)
            PTW_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = PTW_WALK;
                end else begin
                    state_nxt_s = PTW_IDLE;
                end
            end
            PTW_WALK: begin
                if (walk_abort_s) begin
                    state_nxt_s = PTW_IDLE;
                end else if (cnt_r == DELAY_ZERO) begin
                    state_nxt_s  = PTW_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_nxt_s = PTW_WALK;
                end
            end
            PTW_RESP: begin
                state_nxt_s = PTW_IDLE;
            end
            default: begin
                state_nxt_s = PTW_IDLE;
            end
        endcase
    end

    // State, latched request and walk countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PTW_IDLE;
            port_r  <= PTW_PORT_I;
            vpage_r <= PAGE_ZERO;
            cnt_r   <= DELAY_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                port_r  <= grant_d_s ? PTW_PORT_D : PTW_PORT_I;
                vpage_r <= grant_d_s ? d_req_vpage : i_req_vpage;
                cnt_r   <= DELAY_INIT;
            end else if ((state_r == PTW_WALK) && (cnt_r != DELAY_ZERO)) begin
                cnt_r <= cnt_r - {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Response registers: loaded on entry to RESP, pulses last exactly one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_resp_valid_r <= 1'b0;
            d_resp_valid_r <= 1'b0;
            resp_vpage_r   <= PAGE_ZERO;
            resp_ppage_r   <= PAGE_ZERO;
            resp_fault_r   <= 1'b0;
        end else begin
            i_resp_valid_r <= enter_resp_s & (port_r == PTW_PORT_I);
            d_resp_valid_r <= enter_resp_s & (port_r == PTW_PORT_D);
            if (enter_resp_s) begin
                resp_vpage_r <= vpage_r;
                resp_ppage_r <= next_page(vpage_r);
                resp_fault_r <= (vpage_r == PAGE_ZERO);
            end else begin
                resp_vpage_r <= resp_vpage_r;
                resp_ppage_r <= resp_ppage_r;
                resp_fault_r <= resp_fault_r;
            end
        end
    end

    // Statistics, counted while the response is presented
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            walks_done_r  <= {CNT_WIDTH{1'b0}};
            faults_seen_r <= {CNT_WIDTH{1'b0}};
        end else if (state_r == PTW_RESP) begin
            walks_done_r  <= walks_done_r + CNT_ONE;
            faults_seen_r <= resp_fault_r ? (faults_seen_r + CNT_ONE) : faults_seen_r;
        end else begin
            walks_done_r  <= walks_done_r;
            faults_seen_r <= faults_seen_r;
        end
    end

    assign i_resp_valid = i_resp_valid_r;
    assign d_resp_valid = d_resp_valid_r;
    assign resp_vpage   = resp_vpage_r;
    assign resp_ppage   = resp_ppage_r;
    assign resp_fault   = resp_fault_r;
    assign walks_done   = walks_done_r;
    assign faults_seen  = faults_seen_r;

endmodule

// File: tb/tb_page_table_walker.sv
// Self-checking bench for page_table_walker: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_page_table_walker;

    localparam int WD = 3;

    logic        clk;
    logic        rst_n;
    logic        i_req_valid, d_req_valid, flush;
    logic [19:0] i_req_vpage, d_req_vpage;
    logic        i_req_ready, d_req_ready;
    logic        i_resp_valid, d_resp_valid, resp_fault;
    logic [19:0] resp_vpage, resp_ppage;
    logic [31:0] walks_done, faults_seen;

    logic        i1_valid;
    logic [19:0] i1_vpage;
    logic        d1_valid, flush1;
    logic [19:0] d1_vpage;
    logic        i1_ready, d1_ready, i1_resp, d1_resp, resp_fault1;
    logic [19:0] resp_vpage1, resp_ppage1;
    logic [31:0] walks1, faults1;

    int unsigned total = 0;
    int unsigned bad   = 0;

    page_table_walker #(.PAGE_WIDTH(20), .WALK_DELAY(3), .DELAY_WIDTH(2), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_vpage(i_req_vpage), .i_req_ready(i_req_ready),
        .d_req_valid(d_req_valid), .d_req_vpage(d_req_vpage), .d_req_ready(d_req_ready),
        .flush(flush), .i_resp_valid(i_resp_valid), .d_resp_valid(d_resp_valid),
        .resp_vpage(resp_vpage), .resp_ppage(resp_ppage), .resp_fault(resp_fault),
        .walks_done(walks_done), .faults_seen(faults_seen)
    );

    page_table_walker #(.PAGE_WIDTH(20), .WALK_DELAY(1), .DELAY_WIDTH(1), .CNT_WIDTH(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i1_valid), .i_req_vpage(i1_vpage), .i_req_ready(i1_ready),
        .d_req_valid(d1_valid), .d_req_vpage(d1_vpage), .d_req_ready(d1_ready),
        .flush(flush1), .i_resp_valid(i1_resp), .d_resp_valid(d1_resp),
        .resp_vpage(resp_vpage1), .resp_ppage(resp_ppage1), .resp_fault(resp_fault1),
        .walks_done(walks1), .faults_seen(faults1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: one outstanding walk described by owner, page and due cycle
    int unsigned cyc;
    bit          m_active;
    bit          m_port;      // 0 = I, 1 = D
    bit          m_last;      // port granted most recently
    logic [19:0] m_vpage;
    int unsigned m_due;
    logic [31:0] m_walks, m_faults;
    bit          exp_i_ready, exp_d_ready, exp_i_resp, exp_d_resp, exp_fault;
    logic [19:0] exp_ppage;

    task automatic model_reset();
        cyc = 0; m_active = 1'b0; m_port = 1'b0; m_last = 1'b1;
        m_vpage = 20'h0; m_due = 0; m_walks = 32'd0; m_faults = 32'd0;
    endtask

    task automatic model_eval();
        exp_i_ready = 1'b0;
        exp_d_ready = 1'b0;
        if (!m_active && !flush) begin
            if (i_req_valid && d_req_valid) begin
                if (m_last) exp_i_ready = 1'b1;
                else        exp_d_ready = 1'b1;
            end else begin
                exp_i_ready = i_req_valid;
                exp_d_ready = d_req_valid;
            end
        end
        exp_i_resp = m_active && (cyc == m_due) && !m_port;
        exp_d_resp = m_active && (cyc == m_due) && m_port;
        exp_ppage  = m_vpage + 20'd1;
        exp_fault  = (m_vpage == 20'd0);
    endtask

    task automatic model_commit();
        if (exp_i_ready || exp_d_ready) begin
            m_active = 1'b1;
            m_port   = exp_d_ready;
            m_vpage  = exp_d_ready ? d_req_vpage : i_req_vpage;
            m_due    = cyc + WD + 1;
            m_last   = exp_d_ready;
        end else if (m_active && cyc == m_due) begin
            m_walks  = m_walks + 32'd1;
            m_faults = m_faults + (m_vpage == 20'd0 ? 32'd1 : 32'd0);
            m_active = 1'b0;
        end else if (m_active) begin
            if (flush || !(m_port ? d_req_valid : i_req_valid) ||
                ((m_port ? d_req_vpage : i_req_vpage) != m_vpage))
                m_active = 1'b0;
        end
        cyc = cyc + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0; flush = 1'b0;
        i_req_vpage = 20'h0; d_req_vpage = 20'h0;
        i1_valid = 1'b0; i1_vpage = 20'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({i_resp_valid, d_resp_valid, resp_fault, resp_vpage, resp_ppage, walks_done, faults_seen} !== 75'd0) begin
            bad++;
            $display("FAIL reset_outputs got vp=%h pp=%h f=%b walks=%0d faults=%0d want all 0",
                     resp_vpage, resp_ppage, resp_fault, walks_done, faults_seen);
        end
        total++;
        if (walks1 !== 32'd0 || i1_resp !== 1'b0) begin
            bad++;
            $display("FAIL reset_dut1 got walks=%0d resp=%b want 0", walks1, i1_resp);
        end
    endtask

    task automatic test_basic();
        apply_reset();
        i_req_valid = 1'b1; i_req_vpage = 20'h00123;
        #1;
        total++;
        if (i_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
            bad++; $display("FAIL basic_accept got i=%b d=%b want i=1 d=0", i_req_ready, d_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            total++;
            if (i_resp_valid !== (k == 4) || d_resp_valid !== 1'b0 || i_req_ready !== 1'b0) begin
                bad++;
                $display("FAIL basic_pulse k=%0d got i=%b d=%b rdy=%b want i=%b d=0 rdy=0",
                         k, i_resp_valid, d_resp_valid, i_req_ready, (k == 4));
            end
            if (k == 4) begin
                total++;
                if (resp_ppage !== 20'h00124 || resp_fault !== 1'b0 || resp_vpage !== 20'h00123) begin
                    bad++;
                    $display("FAIL basic_data got pp=%h f=%b vp=%h want pp=00124 f=0 vp=00123",
                             resp_ppage, resp_fault, resp_vpage);
                end
                i_req_valid = 1'b0;
            end
        end
        total++;
        if (walks_done !== 32'd1 || faults_seen !== 32'd0) begin
            bad++; $display("FAIL basic_count got walks=%0d faults=%0d want 1 0", walks_done, faults_seen);
        end
    endtask

    task automatic test_arbitration();
        logic [19:0] want_pp [4];
        bit          want_d  [4];
        want_pp = '{20'h11, 20'h21, 20'h31, 20'h51};
        want_d  = '{1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        i_req_valid = 1'b1; i_req_vpage = 20'h10;
        d_req_valid = 1'b1; d_req_vpage = 20'h20;
        for (int w = 0; w < 4; w++) begin
            #1;
            total++;
            if (i_req_ready !== !want_d[w] || d_req_ready !== want_d[w]) begin
                bad++;
                $display("FAIL arb_grant walk=%0d got i=%b d=%b want i=%b d=%b",
                         w, i_req_ready, d_req_ready, !want_d[w], want_d[w]);
            end
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk); #1;
                total++;
                if (i_resp_valid !== (k == 4 && !want_d[w]) || d_resp_valid !== (k == 4 && want_d[w])) begin
                    bad++;
                    $display("FAIL arb_pulse walk=%0d k=%0d got i=%b d=%b", w, k, i_resp_valid, d_resp_valid);
                end
            end
            total++;
            if (resp_ppage !== want_pp[w]) begin
                bad++; $display("FAIL arb_data walk=%0d got pp=%h want %h", w, resp_ppage, want_pp[w]);
            end
            if (want_d[w]) d_req_valid = 1'b0;
            else           i_req_valid = 1'b0;
            if (w == 1) begin
                i_req_valid = 1'b1; i_req_vpage = 20'h30;
            end else if (w == 2) begin
                i_req_valid = 1'b1; i_req_vpage = 20'h40;
                d_req_valid = 1'b1; d_req_vpage = 20'h50;
            end
            @(negedge clk);
        end
        #1;
        total++;
        if (walks_done !== 32'd4 || i_req_ready !== 1'b1) begin
            bad++; $display("FAIL arb_final got walks=%0d i_rdy=%b want 4 1", walks_done, i_req_ready);
        end
        i_req_valid = 1'b0;
    endtask

    task automatic test_fault_wrap();
        apply_reset();
        d_req_valid = 1'b1; d_req_vpage = 20'h0;
        for (int k = 1; k <= 4; k++) begin @(negedge clk); end
        #1;
        total++;
        if (d_resp_valid !== 1'b1 || i_resp_valid !== 1'b0 || resp_ppage !== 20'h00001 || resp_fault !== 1'b1) begin
            bad++;
            $display("FAIL fault_zero got d=%b i=%b pp=%h f=%b want 1 0 00001 1",
                     d_resp_valid, i_resp_valid, resp_ppage, resp_fault);
        end
        d_req_vpage = 20'hFFFFF;
        @(negedge clk); #1;
        total++;
        if (faults_seen !== 32'd1 || walks_done !== 32'd1 || d_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL fault_count got faults=%0d walks=%0d rdy=%b want 1 1 1", faults_seen, walks_done, d_req_ready);
        end
        for (int k = 1; k <= 4; k++) begin @(negedge clk); end
        #1;
        total++;
        if (d_resp_valid !== 1'b1 || resp_ppage !== 20'h0 || resp_fault !== 1'b0 || resp_vpage !== 20'hFFFFF) begin
            bad++;
            $display("FAIL fault_wrap got d=%b pp=%h f=%b vp=%h want 1 00000 0 fffff",
                     d_resp_valid, resp_ppage, resp_fault, resp_vpage);
        end
        d_req_valid = 1'b0;
        @(negedge clk); #1;
        total++;
        if (walks_done !== 32'd2 || faults_seen !== 32'd1) begin
            bad++; $display("FAIL wrap_count got walks=%0d faults=%0d want 2 1", walks_done, faults_seen);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        i_req_valid = 1'b1; i_req_vpage = 20'h55;
        @(negedge clk);
        flush = 1'b1;
        #1;
        total++;
        if (i_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
            bad++; $display("FAIL abort_flush_rdy got i=%b d=%b want 0 0", i_req_ready, d_req_ready);
        end
        @(negedge clk);
        flush = 1'b0; i_req_valid = 1'b0;
        d_req_valid = 1'b1; d_req_vpage = 20'h66;
        #1;
        total++;
        if (d_req_ready !== 1'b1) begin
            bad++; $display("FAIL abort_flush_reaccept got d_rdy=%b want 1", d_req_ready);
        end
        @(negedge clk);
        d_req_valid = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b1; i_req_vpage = 20'h77;
        #1;
        total++;
        if (i_req_ready !== 1'b1) begin
            bad++; $display("FAIL abort_drop_reaccept got i_rdy=%b want 1", i_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            total++;
            if (i_resp_valid !== (k == 4) || d_resp_valid !== 1'b0) begin
                bad++; $display("FAIL abort_pulse k=%0d got i=%b d=%b", k, i_resp_valid, d_resp_valid);
            end
            if (k == 4) i_req_valid = 1'b0;
        end
        total++;
        if (walks_done !== 32'd1 || faults_seen !== 32'd0 || resp_ppage !== 20'h78) begin
            bad++;
            $display("FAIL abort_count got walks=%0d faults=%0d pp=%h want 1 0 78", walks_done, faults_seen, resp_ppage);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        i_req_valid = 1'b1; i_req_vpage = 20'h0;
        for (int k = 1; k <= 4; k++) begin @(negedge clk); end
        i_req_vpage = 20'h200;
        @(negedge clk); #1;
        total++;
        if (i_req_ready !== 1'b1 || walks_done !== 32'd1 || faults_seen !== 32'd1) begin
            bad++;
            $display("FAIL areset_pre got rdy=%b walks=%0d faults=%0d want 1 1 1", i_req_ready, walks_done, faults_seen);
        end
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({i_resp_valid, d_resp_valid, resp_fault, resp_vpage, resp_ppage, walks_done, faults_seen} !== 75'd0) begin
            bad++;
            $display("FAIL areset_clear got pp=%h f=%b walks=%0d faults=%0d want all 0",
                     resp_ppage, resp_fault, walks_done, faults_seen);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (i_req_ready !== 1'b1) begin
            bad++; $display("FAIL areset_reaccept got i_rdy=%b want 1", i_req_ready);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk); #1;
            total++;
            if (i_resp_valid !== (k == 4)) begin
                bad++; $display("FAIL areset_pulse k=%0d got %b want %b", k, i_resp_valid, (k == 4));
            end
            if (k == 4) i_req_valid = 1'b0;
        end
        total++;
        if (walks_done !== 32'd1 || faults_seen !== 32'd0 || resp_ppage !== 20'h201) begin
            bad++;
            $display("FAIL areset_after got walks=%0d faults=%0d pp=%h want 1 0 201", walks_done, faults_seen, resp_ppage);
        end
    endtask

    task automatic test_back_to_back_wd1();
        logic [19:0] exp_vp;
        apply_reset();
        exp_vp = 20'h100;
        i1_valid = 1'b1; i1_vpage = exp_vp;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++;
            if (i1_resp !== (c % 3 == 2) || d1_resp !== 1'b0 || d1_ready !== 1'b0) begin
                bad++;
                $display("FAIL wd1_pulse c=%0d got i=%b d=%b want i=%b d=0", c, i1_resp, d1_resp, (c % 3 == 2));
            end
            if (c % 3 == 0) begin
                total++;
                if (i1_ready !== 1'b1) begin
                    bad++; $display("FAIL wd1_ready c=%0d got %b want 1", c, i1_ready);
                end
            end
            if (c % 3 == 2) begin
                total++;
                if (resp_ppage1 !== exp_vp + 20'd1 || resp_vpage1 !== exp_vp || resp_fault1 !== 1'b0) begin
                    bad++;
                    $display("FAIL wd1_data c=%0d got pp=%h vp=%h want pp=%h vp=%h",
                             c, resp_ppage1, resp_vpage1, exp_vp + 20'd1, exp_vp);
                end
                exp_vp = exp_vp + 20'd7;
                i1_vpage = exp_vp;
            end
        end
        i1_valid = 1'b0;
        @(negedge clk); #1;
        total++;
        if (walks1 !== 32'd4 || faults1 !== 32'd0) begin
            bad++; $display("FAIL wd1_count got walks=%0d faults=%0d want 4 0", walks1, faults1);
        end
    endtask

    function automatic logic [19:0] rand_page();
        case ($urandom_range(0, 3))
            0:       return 20'h0;
            1:       return 20'hFFFFF;
            default: return 20'($urandom);
        endcase
    endfunction

    task automatic test_random();
        apply_reset();
        model_reset();
        for (int n = 0; n < 2000; n++) begin
            if (n > 0) @(negedge clk);
            if (!i_req_valid) begin
                if ($urandom_range(0, 3) == 0) begin i_req_valid = 1'b1; i_req_vpage = rand_page(); end
            end else if ($urandom_range(0, 59) == 0) i_req_valid = 1'b0;
            else if ($urandom_range(0, 59) == 0) i_req_vpage = i_req_vpage ^ 20'h1;
            if (!d_req_valid) begin
                if ($urandom_range(0, 3) == 0) begin d_req_valid = 1'b1; d_req_vpage = rand_page(); end
            end else if ($urandom_range(0, 59) == 0) d_req_valid = 1'b0;
            else if ($urandom_range(0, 59) == 0) d_req_vpage = d_req_vpage ^ 20'h2;
            flush = ($urandom_range(0, 24) == 0);
            #1;
            model_eval();
            total++;
            if (i_req_ready !== exp_i_ready || d_req_ready !== exp_d_ready) begin
                bad++;
                $display("FAIL rand_ready n=%0d got i=%b d=%b want i=%b d=%b",
                         n, i_req_ready, d_req_ready, exp_i_ready, exp_d_ready);
            end
            total++;
            if (i_resp_valid !== exp_i_resp || d_resp_valid !== exp_d_resp) begin
                bad++;
                $display("FAIL rand_pulse n=%0d got i=%b d=%b want i=%b d=%b",
                         n, i_resp_valid, d_resp_valid, exp_i_resp, exp_d_resp);
            end
            if (exp_i_resp || exp_d_resp) begin
                total++;
                if (resp_vpage !== m_vpage || resp_ppage !== exp_ppage || resp_fault !== exp_fault) begin
                    bad++;
                    $display("FAIL rand_data n=%0d got vp=%h pp=%h f=%b want vp=%h pp=%h f=%b",
                             n, resp_vpage, resp_ppage, resp_fault, m_vpage, exp_ppage, exp_fault);
                end
            end
            total++;
            if (walks_done !== m_walks || faults_seen !== m_faults) begin
                bad++;
                $display("FAIL rand_count n=%0d got walks=%0d faults=%0d want %0d %0d",
                         n, walks_done, faults_seen, m_walks, m_faults);
            end
            if (exp_i_resp) i_req_valid = 1'b0;
            if (exp_d_resp) d_req_valid = 1'b0;
            model_commit();
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req_valid = 1'b0; d_req_valid = 1'b0; flush = 1'b0;
        i_req_vpage = 20'h0; d_req_vpage = 20'h0;
        i1_valid = 1'b0; i1_vpage = 20'h0;
        d1_valid = 1'b0; d1_vpage = 20'h0; flush1 = 1'b0;
        model_reset();
        test_reset();
        test_arbitration();
        test_basic();
        test_fault_wrap();
        test_abort();
        test_async_reset();
        test_back_to_back_wd1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
